// File: rtl/rr_mux_arb_pkg.sv
// Shared encodings for the round-robin 2:1 channel arbiter.
// The FSM state values and the beat-counter width live here so every file agrees on them.
package rr_mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic valid;
        logic idx;
    } pick_t;

    function automatic logic [1:0] idx2gnt(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    function automatic state_t idx2state(input logic idx);
        return idx ? GRANT1 : GRANT0;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// rr_pick: combinational two-way round-robin picker.
// On a tie the requester that is not `last` wins; a lone requester always wins.
module rr_pick
    import rr_mux_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick_valid,
    output logic       pick_idx
);

    pick_t p;

    always_comb begin
        p.valid = |req;
        p.idx   = (req == 2'b11) ? ~last : req[1];
    end

    assign pick_valid = p.valid;
    assign pick_idx   = p.idx;

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin FSM driving a registered valid/ready 2:1 channel, BURST beats per grant.
// Optional macro RR_MUX_ARB_LOCK_EN adds a lock input that lets the owner exceed the BURST limit.
module rr_mux_arbiter
    import rr_mux_arb_pkg::*;
#(
    parameter int W     = 2,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    input  logic [W-1:0] data0,
    input  logic [W-1:0] data1,
`ifdef RR_MUX_ARB_LOCK_EN
    input  logic [1:0]   lock,
`endif
    output logic [1:0]   ack,
    output logic [1:0]   gnt,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    state_t           state;
    logic             last;
    logic [CNT_W-1:0] cnt;

    logic       slot_free;
    logic       own;
    logic       acked;
    logic       locked;
    logic       at_limit;
    logic       rel;
    logic       pick_valid;
    logic       pick_idx;
    logic [1:0] lock_w;

`ifdef RR_MUX_ARB_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = 2'b00;
`endif

    assign slot_free = !out_valid || out_ready;
    assign own       = (state == GRANT1);

    always_comb begin
        ack = 2'b00;
        if (state == GRANT0) ack[0] = req[0] && slot_free;
        if (state == GRANT1) ack[1] = req[1] && slot_free;
    end

    assign acked    = |ack;
    assign locked   = lock_w[own];
    assign at_limit = (cnt == CNT_W'(BURST - 1));

    // Owner gives up the channel when it stops requesting or spends its last beat.
    assign rel = (state != IDLE) && (!req[own] || (acked && at_limit && !locked));

    // In a grant state last equals the owner, so one picker serves IDLE and release.
    rr_pick u_pick (
        .req        (req),
        .last       (last),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            last      <= 1'b1;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (acked) begin
                out_data  <= own ? data1 : data0;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == IDLE || rel) begin
                cnt <= '0;
                if (pick_valid) begin
                    state <= idx2state(pick_idx);
                    gnt   <= idx2gnt(pick_idx);
                    last  <= pick_idx;
                end else begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            end else if (acked && !(locked && at_limit)) begin
                // A locked owner parks the counter at the limit instead of wrapping.
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: BURST=4 and BURST=1 instances checked every cycle against a beat-count model.
module tb_rr_mux_arbiter;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req = 2'b11;
    logic [W-1:0] data0 = 2'b01;
    logic [W-1:0] data1 = 2'b10;
    logic [1:0]   lock = 2'b00;
    logic         out_ready = 1'b1;

    logic [1:0]   ack_a [2];
    logic [1:0]   gnt_a [2];
    logic         ov_a  [2];
    logic [W-1:0] od_a  [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.W(W), .BURST(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
`ifdef RR_MUX_ARB_LOCK_EN
        .lock(lock),
`endif
        .ack(ack_a[0]), .gnt(gnt_a[0]), .out_valid(ov_a[0]), .out_data(od_a[0]),
        .out_ready(out_ready)
    );

    rr_mux_arbiter #(.W(W), .BURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
`ifdef RR_MUX_ARB_LOCK_EN
        .lock(lock),
`endif
        .ack(ack_a[1]), .gnt(gnt_a[1]), .out_valid(ov_a[1]), .out_data(od_a[1]),
        .out_ready(out_ready)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner (-1 = none), beats spent in the current grant, last winner, output register.
    int           bl   [2] = '{4, 1};
    int           own  [2] = '{-1, -1};
    int           beats[2] = '{0, 0};
    int           mlast[2] = '{1, 1};
    bit           mov  [2] = '{0, 0};
    logic [W-1:0] mod  [2] = '{2'b00, 2'b00};

    function automatic int pick(input logic [1:0] r, input int l);
        if (r == 2'b11) return (l == 0) ? 1 : 0;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
    endfunction

    function automatic logic [1:0] mack(input int k);
        if (own[k] < 0) return 2'b00;
        if (req[own[k]] && (!mov[k] || out_ready)) return (own[k] == 0) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [1:0] mgnt(input int k);
        if (own[k] < 0) return 2'b00;
        return (own[k] == 0) ? 2'b01 : 2'b10;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                own[k] = -1; beats[k] = 0; mlast[k] = 1; mov[k] = 0; mod[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit a;
                int n;
                a = (mack(k) != 2'b00);
                if (a) begin
                    mod[k] = (own[k] == 1) ? data1 : data0;
                    mov[k] = 1;
                    beats[k]++;
                end else if (mov[k] && out_ready) begin
                    mov[k] = 0;
                end
                if (own[k] < 0) begin
                    n = pick(req, mlast[k]);
                    if (n >= 0) begin own[k] = n; mlast[k] = n; beats[k] = 0; end
                end else if (!req[own[k]] || (a && beats[k] >= bl[k] && !lock[own[k]])) begin
                    n = pick(req, own[k]);
                    own[k] = n;
                    if (n >= 0) mlast[k] = n;
                    beats[k] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("gnt[b%0d]", bl[k]), gnt_a[k], mgnt(k));
            chk($sformatf("ack[b%0d]", bl[k]), ack_a[k], mack(k));
            chk($sformatf("out_valid[b%0d]", bl[k]), ov_a[k], mov[k]);
            chk($sformatf("out_data[b%0d]", bl[k]), od_a[k], mod[k]);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct { logic [1:0] r; logic rdy; } vec_t;
    vec_t mix [12] = '{
        '{2'b11, 1'b1}, '{2'b11, 1'b0}, '{2'b11, 1'b1}, '{2'b01, 1'b1},
        '{2'b10, 1'b0}, '{2'b10, 1'b1}, '{2'b00, 1'b0}, '{2'b00, 1'b1},
        '{2'b10, 1'b1}, '{2'b11, 1'b1}, '{2'b01, 1'b0}, '{2'b11, 1'b1}
    };

    initial begin
        // Reset held with both requesting.
        #12;
        chk("rst gnt", gnt_a[0], 2'b00);
        chk("rst out_valid", ov_a[0], 1'b0);
        chk("rst out_data", od_a[0], 2'b00);
        chk("rst ack", ack_a[0], 2'b00);
        rst_n = 1'b1;

        // Fairness: requester 0 wins the first tie, 4 beats of 01 then 10.
        cyc(); #1;
        chk("first gnt", gnt_a[0], 2'b01);
        chk("first ack", ack_a[0], 2'b01);
        chk("first valid", ov_a[0], 1'b0);
        chk("b1 first gnt", gnt_a[1], 2'b01);
        cyc(); #1;
        chk("beat1 data", od_a[0], 2'b01);
        chk("beat1 valid", ov_a[0], 1'b1);
        chk("b1 alternate", gnt_a[1], 2'b10);
        cyc(); #1;
        chk("b1 alternate back", gnt_a[1], 2'b01);
        cyc(2); #1;
        chk("switch after 4", gnt_a[0], 2'b10);
        cyc(); #1;
        chk("req1 data", od_a[0], 2'b10);
        cyc(6);

        // Single requester with burst re-entry.
        req = 2'b01; data0 = 2'b10;
        cyc(6); #1;
        chk("single ack", ack_a[0], 2'b01);
        chk("single data", od_a[0], 2'b10);
        cyc(2);

        // Back-pressure mid-burst.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall ack", ack_a[0], 2'b00);
            chk("stall data", od_a[0], 2'b10);
            cyc();
        end
        out_ready = 1'b1;
        cyc(6);

        // Drop of requester 0 while requester 1 waits.
        req = 2'b11; data1 = 2'b01;
        cyc(2);
        req = 2'b10;
        cyc(); #1;
        chk("drop gnt", gnt_a[0], 2'b10);
        cyc(2);

        // Asynchronous reset mid-burst, between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("async gnt", gnt_a[0], 2'b00);
        chk("async valid", ov_a[0], 1'b0);
        chk("async data", od_a[0], 2'b00);
        chk("async ack", ack_a[0], 2'b00);
        rst_n = 1'b1;
        req = 2'b11; data0 = 2'b11; data1 = 2'b00;
        cyc(8);

        foreach (mix[i]) begin
            req = mix[i].r;
            out_ready = mix[i].rdy;
            data0 = data0 + 2'd1;
            cyc();
        end
        out_ready = 1'b1;

`ifdef RR_MUX_ARB_LOCK_EN
        req = 2'b00;
        cyc(2);
        req = 2'b01; lock = 2'b01;
        cyc();
        req = 2'b11;
        cyc(8); #1;
        chk("lock hold", gnt_a[0], 2'b01);
        req = 2'b10;
        cyc(); #1;
        chk("lock release", gnt_a[0], 2'b10);
        lock = 2'b00;
        cyc(4);
`endif

        req = 2'b00;
        cyc(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 2:1 data channel of W-bit words.
- Two requesters compete for one registered output channel that uses a valid/ready handshake.
- The FSM owns the channel select and limits each grant to BURST beats, which keeps arbitration fair.
- Sits between two producer blocks and a single downstream consumer in the lab datapath.

Parameters:
- W, 2, data width of each requester word and of out_data.
- BURST, 4, maximum beats per grant before a forced re-arbitration; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2  req[i] high means requester i has a word on data_i.
- data0  input  W  requester 0 word.
- data1  input  W  requester 1 word.
- ack  output  2  ack[i] high for one cycle means data_i was accepted this edge (combinational).
- gnt  output  2  one-hot current owner; 00 when idle (registered).
- out_valid  output  1  out_data holds a valid word (registered).
- out_data  output  W  shared channel word (registered).
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values (asynchronous, on rst_n low):
  - state=IDLE, gnt=00, out_valid=0, out_data=0, ack=00, beat counter=0.
  - last=1, so requester 0 wins the first tie.
- States: IDLE, GRANT0, GRANT1.
- IDLE transitions:
  - Only one req high: go to that requester's GRANT state.
  - Both high: grant the requester that is not `last`.
  - On every grant entry: last := granted index, counter := 0.
- Slot free: slot_free = !out_valid || out_ready.
- In GRANTi, ack[i] = req[i] && slot_free. ack is never asserted in IDLE, and never for the non-granted requester.
- On an ack edge:
  - out_data := data_i, out_valid := 1, counter += 1.
- Without an ack edge:
  - If out_valid && out_ready, then out_valid := 0.
  - If out_valid && !out_ready, out_data holds stable.
- Release from GRANTi happens when either condition is true:
  - req[i] is low at the edge, with no ack that cycle; or
  - an ack occurs with counter == BURST-1.
- On release:
  - If req[j] (the other requester) is high, go to GRANTj.
  - Otherwise, if req[i] is still high, re-enter GRANTi with counter := 0.
  - Otherwise go to IDLE.
- gnt is updated on the same edge as the state.
- Latency:
  - req rising in IDLE at cycle N gives gnt at N+1.
  - The first ack is in cycle N+1 if the slot is free.
  - out_valid is high from N+2.
  - Back-to-back beats at full throughput while out_ready=1.
- Boundaries:
  - BURST=1: requesters alternate every beat when both request.
  - Back-pressure (out_ready=0) stalls ack; the counter does not advance.
  - req[i] dropping while stalled releases the grant; a word already in out_data stays valid until accepted.
  - Reset mid-burst aborts the grant and drops the registered word.
  - There is no combinational path from out_ready to gnt.

Optional Feature:
- Macro: RR_MUX_ARB_LOCK_EN.
- With the macro defined:
  - Adds input port lock, 2 bits.
  - While in GRANTi with lock[i] high, the BURST limit is ignored; the counter saturates at BURST-1.
  - Release then occurs only when req[i] drops.
- Without the macro: the lock port is absent and the BURST limit always applies.

Decomposition:
- Package rr_mux_arb_pkg holds:
  - State encoding constants: IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2.
  - Counter width constant CNT_W=4.
- One sub-module, rr_pick: a combinational two-way round-robin picker.
  - Inputs: req, last.
  - Outputs: pick_valid, pick_idx.
  - Instantiated once; used for both the IDLE and release decisions.

Test Plan:
- Reset: hold rst_n=0 with req=11 -> gnt=00, out_valid=0, out_data=00, ack=00; release reset -> next edge gnt=01.
- Single requester: req=01, data0=2'b10, out_ready=1 -> ack[0] high every cycle from N+1, out_data=10 valid from N+2; with BURST=4, gnt re-enters 01 after each 4 beats (counter reset).
- Fairness: req=11, data0=01, data1=10, BURST=4, out_ready=1 -> 4 beats of 01, then 4 beats of 10, alternating; gnt toggles 01/10.
- Back-pressure: mid-burst out_ready=0 for 3 cycles -> ack=00, out_data stable, counter frozen; resumes with the remaining beats once out_ready=1.
- Drop and async reset: req[0] falls at beat 2 with req[1]=1 -> gnt=10 on the next edge; rst_n pulsed low mid-burst -> outputs clear immediately without waiting for clk.
- Lock (RR_MUX_ARB_LOCK_EN): lock=01, req=11 -> requester 0 holds the channel past 4 beats until req[0] drops, then gnt=10.
